// File: rtl/popcount_stream.sv
// ============================================================================
// Module   : popcount_stream
// Brief    : Three-stage streaming ones counter with per-word or per-packet
//            accumulation. Define POPCOUNT_STREAM_SAT_EN for saturating sums.
// Revision : 1.0
// ============================================================================
`default_nettype none

module popcount_stream #(
    parameter int DATA_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 32,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_count,
    output logic                  out_sat
);

    localparam int NUM_CHUNKS      = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CHUNK_CNT_WIDTH = $clog2(CHUNK_WIDTH + 1);
    localparam int CNT_WIDTH       = $clog2(DATA_WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    function automatic logic [CHUNK_CNT_WIDTH-1:0] f_popcount(input logic [CHUNK_WIDTH-1:0] v);
        logic [CHUNK_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < CHUNK_WIDTH; b++) begin
            cnt = cnt + CHUNK_CNT_WIDTH'(v[b]);
        end
        return cnt;
    endfunction

    logic                                      w_advance;
    logic [NUM_CHUNKS-1:0][CHUNK_CNT_WIDTH-1:0] w_chunk_cnt;
    logic [CNT_WIDTH-1:0]                      w_word_sum;

    logic                                      s1_valid_q, s1_last_q, s1_mode_q;
    logic [NUM_CHUNKS-1:0][CHUNK_CNT_WIDTH-1:0] s1_cnt_q;
    logic                                      s2_valid_q, s2_last_q, s2_mode_q;
    logic [CNT_WIDTH-1:0]                      s2_sum_q;

    logic [0:0]           state_q, state_d;
    logic                 pkt_mode_q, pkt_mode_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_acc_q, sat_acc_d;
    logic [ACC_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sat_q, out_sat_d;

    logic                 w_eff_mode;
    logic [ACC_WIDTH-1:0] w_base;
    logic                 w_sat_base;
    logic [ACC_WIDTH-1:0] w_add;
    logic                 w_add_ovf;

    // Every stage moves together; a held result freezes the whole pipe.
    assign w_advance = !out_valid_q || out_ready;
    assign in_ready  = w_advance;

    generate
        for (genvar i = 0; i < NUM_CHUNKS; i++) begin : g_chunk
            assign w_chunk_cnt[i] = f_popcount(in_data[i*CHUNK_WIDTH +: CHUNK_WIDTH]);
        end
    endgenerate

    always_comb begin
        w_word_sum = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            w_word_sum = w_word_sum + CNT_WIDTH'(s1_cnt_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_cnt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_sum_q   <= '0;
        end else if (w_advance) begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_last;
            s1_mode_q  <= mode;
            s1_cnt_q   <= w_chunk_cnt;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_mode_q  <= s1_mode_q;
            s2_sum_q   <= w_word_sum;
        end
    end

    // A packet's mode is latched at its first beat; later beats' tags are ignored.
    assign w_eff_mode = (state_q == ST_IDLE) ? s2_mode_q : pkt_mode_q;
    assign w_base     = (state_q == ST_IDLE) ? '0 : acc_q;
    assign w_sat_base = (state_q == ST_IDLE) ? 1'b0 : sat_acc_q;

`ifdef POPCOUNT_STREAM_SAT_EN
    localparam int ACC_EXT_WIDTH = ACC_WIDTH + 1;
    logic [ACC_EXT_WIDTH-1:0] w_add_ext;
    assign w_add_ext = {1'b0, w_base} + ACC_EXT_WIDTH'(s2_sum_q);
    assign w_add_ovf = w_add_ext[ACC_WIDTH];
    assign w_add     = w_add_ovf ? {ACC_WIDTH{1'b1}} : w_add_ext[ACC_WIDTH-1:0];
`else
    assign w_add     = w_base + ACC_WIDTH'(s2_sum_q);
    assign w_add_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_advance && s2_valid_q) begin
            if (!w_eff_mode || s2_last_q) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_OPEN;
            end
        end
    end

    always_comb begin
        pkt_mode_d  = pkt_mode_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        if (w_advance) begin
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                pkt_mode_d = w_eff_mode;
                if (!w_eff_mode) begin
                    out_count_d = ACC_WIDTH'(s2_sum_q);
                    out_sat_d   = 1'b0;
                    out_valid_d = 1'b1;
                end else if (s2_last_q) begin
                    out_count_d = w_add;
                    out_sat_d   = w_sat_base | w_add_ovf;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d     = w_add;
                    sat_acc_d = w_sat_base | w_add_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_mode_q  <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            pkt_mode_q  <= pkt_mode_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_popcount_stream.sv
// ============================================================================
// Module   : tb_popcount_stream
// Brief    : Scoreboard bench for popcount_stream with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_popcount_stream;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         in_last;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_count;
    logic         out_sat;

    int total = 0;
    int bad   = 0;
    int exp_cnt_q[$];
    bit exp_sat_q[$];
    int total_waits;

    popcount_stream #(
        .DATA_WIDTH (256),
        .CHUNK_WIDTH(32),
        .ACC_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .out_sat  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every handshaked result is checked against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_cnt_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got count=%0d sat=%0d, required no output", out_count, out_sat);
            end else begin
                int ec;
                bit es;
                ec = exp_cnt_q.pop_front();
                es = exp_sat_q.pop_front();
                if (int'(out_count) != ec || out_sat != es) begin
                    bad++;
                    $display("FAIL result: got count=%0d sat=%0d, required count=%0d sat=%0d", out_count, out_sat, ec, es);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [255:0] d, input logic l, input logic m,
                        input bit push, input int ec, input bit es);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, required 1", waits);
        end else if (push) begin
            exp_cnt_q.push_back(ec);
            exp_sat_q.push_back(es);
        end
        total_waits += waits;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [255:0] ones;
    logic [255:0] spread;

    initial begin
        ones      = {256{1'b1}};
        spread    = {8{32'h8000_0001}};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        total_waits = 0;

        repeat (2) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_count", int'(out_count), 0);
        check("reset_out_sat", int'(out_sat), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Latency: all-ones word appears after the third edge following accept.
        send(ones, 1'b0, 1'b0, 1'b1, 256, 1'b0);
        @(negedge clk);
        check("lat_edge1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge2_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge3_valid", int'(out_valid), 1);
        check("lat_edge3_count", int'(out_count), 256);
        check("lat_edge3_sat", int'(out_sat), 0);
        idle(4);

        // Back-to-back mode-0 words.
        total_waits = 0;
        send(256'h0,  1'b0, 1'b0, 1'b1, 0,   1'b0);
        send(256'h1,  1'b1, 1'b0, 1'b1, 1,   1'b0);
        send(256'hFF, 1'b0, 1'b0, 1'b1, 8,   1'b0);
        send(ones,    1'b0, 1'b0, 1'b1, 256, 1'b0);
        send(spread,  1'b0, 1'b0, 1'b1, 16,  1'b0);
        check("b2b_stall_cycles", total_waits, 0);
        idle(6);

        // Packet of three beats; mode flips on later beats must be ignored.
        send(256'hF,  1'b0, 1'b1, 1'b0, 0,  1'b0);
        send(256'hFF, 1'b0, 1'b0, 1'b0, 0,  1'b0);
        send(256'h1,  1'b1, 1'b0, 1'b1, 13, 1'b0);
        idle(6);

        // Back-pressure: three results queued while out_ready is low.
        out_ready = 1'b0;
        send(256'h3,    1'b0, 1'b0, 1'b1, 2,   1'b0);
        send(256'hF0F,  1'b0, 1'b0, 1'b1, 8,   1'b0);
        send(ones,      1'b0, 1'b0, 1'b1, 256, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_count", int'(out_count), 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(8);
        check("stall_drained", exp_cnt_q.size(), 0);

        // Long packet overflowing the 16-bit accumulator.
        for (int k = 0; k < 299; k++) begin
            send(ones, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        end
`ifdef POPCOUNT_STREAM_SAT_EN
        send(ones, 1'b1, 1'b1, 1'b1, 65535, 1'b1);
`else
        send(ones, 1'b1, 1'b1, 1'b1, 11264, 1'b0);
`endif
        // Saturation flag must not leak into the next packet.
        send(256'h1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle(6);

        // Reset in the middle of an open packet.
        send(ones, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        send(ones, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        send(256'h3, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        idle(6);

        begin
            int waited;
            waited = 0;
            while (exp_cnt_q.size() != 0 && waited < 50) begin
                waited++;
                @(negedge clk);
            end
        end
        check("final_queue_empty", exp_cnt_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
